dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the pipeline MEM stage (lw/sw) and port 1 is the debug/DMA loader.
- Arbitrates between them round-robin and inserts configurable wait states to model slow memory.
- Drives exactly one read or write strobe per transaction into the data memory.
- Checks alignment and range, and returns a single-cycle response per accepted request.

---
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the MEM stage
// (port 0) and the debug/DMA loader (port 1), with configurable wait states.
module dmem_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic        rsp0_err,
  output logic [31:0] rsp0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic        rsp1_err,
  output logic [31:0] rsp1_rdata,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_RESP} state_t;

  localparam logic [3:0]  CNT_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        ptr_reg, owner_reg, we_reg, err_reg;
  logic [31:0] addr_reg, wdata_reg, rdata0_reg, rdata1_reg;

  logic        any_valid, grant, handshake, req_bad;
  logic [31:0] sel_addr;

  assign any_valid = req0_valid | req1_valid;
  // With a single requester it wins outright; the pointer only breaks ties.
  assign grant     = (req0_valid & req1_valid) ? ptr_reg : req1_valid;
  assign handshake = (state_reg == ST_IDLE) & any_valid;
  assign sel_addr  = grant ? req1_addr : req0_addr;
  assign req_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= DEPTH_IDX);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_valid) begin
          if (req_bad) begin
            state_next = ST_RESP;
          end else if (WAIT_STATES == 0) begin
            state_next = ST_ACCESS;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_ACCESS;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= 4'd0;
      ptr_reg    <= 1'b0;
      owner_reg  <= 1'b0;
      we_reg     <= 1'b0;
      err_reg    <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      rdata0_reg <= 32'd0;
      rdata1_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (handshake) begin
        we_reg    <= grant ? req1_we : req0_we;
        addr_reg  <= sel_addr;
        wdata_reg <= grant ? req1_wdata : req0_wdata;
        owner_reg <= grant;
        err_reg   <= req_bad;
        ptr_reg   <= ~grant;
      end
      if ((state_reg == ST_ACCESS) && !we_reg) begin
        if (owner_reg) rdata1_reg <= mem_rdata_i;
        else           rdata0_reg <= mem_rdata_i;
      end
    end
  end

  assign req0_ready  = handshake & ~grant;
  assign req1_ready  = handshake & grant;

  assign mem_read_o  = (state_reg == ST_ACCESS) & ~we_reg;
  assign mem_write_o = (state_reg == ST_ACCESS) & we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign busy_o      = (state_reg != ST_IDLE);

  // Error responses show zero data without disturbing the held read value.
  assign rsp0_valid  = (state_reg == ST_RESP) & ~owner_reg;
  assign rsp1_valid  = (state_reg == ST_RESP) & owner_reg;
  assign rsp0_err    = rsp0_valid & err_reg;
  assign rsp1_err    = rsp1_valid & err_reg;
  assign rsp0_rdata  = rsp0_err ? 32'd0 : rdata0_reg;
  assign rsp1_rdata  = rsp1_err ? 32'd0 : rdata1_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (WAIT_STATES=1 and 0) against a
// transaction-schedule model, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid [2][2];
  logic        req_we    [2][2];
  logic [31:0] req_addr  [2][2];
  logic [31:0] req_wdata [2][2];
  logic        req_ready [2][2];
  logic        rsp_valid [2][2];
  logic        rsp_err   [2][2];
  logic [31:0] rsp_rdata [2][2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  dmem_arbiter #(.WAIT_STATES(1), .DEPTH_WORDS(256)) u_dut_ws1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0][0]), .req0_we(req_we[0][0]), .req0_addr(req_addr[0][0]),
    .req0_wdata(req_wdata[0][0]), .req0_ready(req_ready[0][0]), .rsp0_valid(rsp_valid[0][0]),
    .rsp0_err(rsp_err[0][0]), .rsp0_rdata(rsp_rdata[0][0]),
    .req1_valid(req_valid[0][1]), .req1_we(req_we[0][1]), .req1_addr(req_addr[0][1]),
    .req1_wdata(req_wdata[0][1]), .req1_ready(req_ready[0][1]), .rsp1_valid(rsp_valid[0][1]),
    .rsp1_err(rsp_err[0][1]), .rsp1_rdata(rsp_rdata[0][1]),
    .mem_read_o(mem_read[0]), .mem_write_o(mem_write[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_rdata_i(mem_rdata[0]), .busy_o(busy[0])
  );

  dmem_arbiter #(.WAIT_STATES(0), .DEPTH_WORDS(256)) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[1][0]), .req0_we(req_we[1][0]), .req0_addr(req_addr[1][0]),
    .req0_wdata(req_wdata[1][0]), .req0_ready(req_ready[1][0]), .rsp0_valid(rsp_valid[1][0]),
    .rsp0_err(rsp_err[1][0]), .rsp0_rdata(rsp_rdata[1][0]),
    .req1_valid(req_valid[1][1]), .req1_we(req_we[1][1]), .req1_addr(req_addr[1][1]),
    .req1_wdata(req_wdata[1][1]), .req1_ready(req_ready[1][1]), .rsp1_valid(rsp_valid[1][1]),
    .rsp1_err(rsp_err[1][1]), .rsp1_rdata(rsp_rdata[1][1]),
    .mem_read_o(mem_read[1]), .mem_write_o(mem_write[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_rdata_i(mem_rdata[1]), .busy_o(busy[1])
  );

  // Data memories seen by each DUT: combinational read, write at the clock edge.
  logic [31:0] env_mem [2][256];
  bit          env_init = 1'b0;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) env_mem[k][i] <= 32'd0;
      env_init <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++)
        if (mem_write[k]) env_mem[k][mem_addr[k][9:2]] <= mem_wdata[k];
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign mem_rdata[gi] = env_mem[gi][mem_addr[gi][9:2]];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: each accepted request schedules its access and response cycles.
  int          m_acc [2];
  int          m_rsp [2];
  logic        m_ptr [2];
  logic        m_we  [2];
  logic        m_own [2];
  logic        m_err [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rd  [2][2];
  logic [31:0] ref_mem [2][256];

  // Observations of the DUT for the directed checks.
  int          hs_cnt      [2][2];
  int          last_hs_cyc [2][2];
  int          rsp_cnt     [2][2];
  int          last_rsp_cyc [2][2];
  logic        last_rsp_err [2][2];
  logic [31:0] last_rsp_rdata [2][2];
  int          wr_pulses [2];
  int          strobes   [2];
  logic [31:0] last_wr_addr [2];
  int          g_log [$];
  int          g_cyc [$];

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cyc %0d: got %h, expected %h", name, k, cyc, act, exp);
  endtask

  task automatic chk1(input string name, input int k, input logic act, input logic exp);
    chk(name, k, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic check_cycle();
    for (int k = 0; k < 2; k++) begin
      logic        idle, any_v, gnt, hs, acc, rv;
      logic [31:0] a;
      if (!rst_n) begin
        m_acc[k] = -10; m_rsp[k] = -10; m_ptr[k] = 1'b0; m_we[k] = 1'b0;
        m_own[k] = 1'b0; m_err[k] = 1'b0; m_addr[k] = 32'd0; m_wdata[k] = 32'd0;
        m_rd[k][0] = 32'd0; m_rd[k][1] = 32'd0;
      end
      idle  = rst_n && (cyc > m_rsp[k]);
      any_v = req_valid[k][0] | req_valid[k][1];
      gnt   = (req_valid[k][0] && req_valid[k][1]) ? m_ptr[k] : req_valid[k][1];
      hs    = idle && any_v;
      acc   = rst_n && (cyc == m_acc[k]);
      chk1("busy", k, busy[k], rst_n && !idle);
      chk1("mem_read", k, mem_read[k], acc && !m_we[k]);
      chk1("mem_write", k, mem_write[k], acc && m_we[k]);
      chk("mem_addr", k, mem_addr[k], m_addr[k]);
      chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
      for (int p = 0; p < 2; p++) begin
        rv = rst_n && (cyc == m_rsp[k]) && (m_own[k] == p[0]);
        chk1("ready", k, req_ready[k][p], hs && (gnt == p[0]));
        chk1("rsp_valid", k, rsp_valid[k][p], rv);
        chk1("rsp_err", k, rsp_err[k][p], rv && m_err[k]);
        chk("rsp_rdata", k, rsp_rdata[k][p], (rv && m_err[k]) ? 32'd0 : m_rd[k][p]);
        if (rsp_valid[k][p]) begin
          rsp_cnt[k][p]++;
          last_rsp_cyc[k][p]   = cyc;
          last_rsp_err[k][p]   = rsp_err[k][p];
          last_rsp_rdata[k][p] = rsp_rdata[k][p];
        end
        if (req_ready[k][p] && req_valid[k][p]) begin
          hs_cnt[k][p]++;
          last_hs_cyc[k][p] = cyc;
          g_log.push_back(p);
          g_cyc.push_back(cyc);
        end
      end
      if (mem_write[k]) begin
        wr_pulses[k]++;
        last_wr_addr[k] = mem_addr[k];
      end
      if (mem_read[k] || mem_write[k]) strobes[k]++;
      if (rst_n) begin
        if (acc) begin
          if (m_we[k]) ref_mem[k][m_addr[k][9:2]] = m_wdata[k];
          else         m_rd[k][m_own[k]] = ref_mem[k][m_addr[k][9:2]];
        end
        if (hs) begin
          a          = req_addr[k][gnt];
          m_own[k]   = gnt;
          m_we[k]    = req_we[k][gnt];
          m_addr[k]  = a;
          m_wdata[k] = req_wdata[k][gnt];
          m_ptr[k]   = !gnt;
          m_err[k]   = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
          if (m_err[k]) begin
            m_acc[k] = -10;
            m_rsp[k] = cyc + 1;
          end else begin
            m_acc[k] = cyc + ws_of(k) + 1;
            m_rsp[k] = cyc + ws_of(k) + 2;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 30; i++) begin
      if (cyc > m_rsp[k]) break;
      step();
    end
    chk1("idle_timeout", k, cyc > m_rsp[k], 1'b1);
  endtask

  task automatic issue(input int k, input int p, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int h0, r0;
    h0 = hs_cnt[k][p];
    r0 = rsp_cnt[k][p];
    req_we[k][p] = we; req_addr[k][p] = addr; req_wdata[k][p] = wdata;
    req_valid[k][p] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (hs_cnt[k][p] != h0) break;
    end
    req_valid[k][p] = 1'b0;
    chk1("handshake_timeout", k, hs_cnt[k][p] != h0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (rsp_cnt[k][p] != r0) break;
      step();
    end
    chk1("response_timeout", k, rsp_cnt[k][p] != r0, 1'b1);
  endtask

  task automatic hold(input int k, input logic use0, input logic use1, input int n);
    g_log.delete();
    g_cyc.delete();
    req_valid[k][0] = use0;
    req_valid[k][1] = use1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (g_log.size() >= n) break;
    end
    req_valid[k][0] = 1'b0;
    req_valid[k][1] = 1'b0;
    chk("grant_count", k, 32'(g_log.size()), 32'(n));
    wait_idle(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) ref_mem[k][i] = 32'd0;
      for (int p = 0; p < 2; p++) begin
        req_valid[k][p] = 1'b0; req_we[k][p] = 1'b0;
        req_addr[k][p] = 32'd0; req_wdata[k][p] = 32'd0;
        hs_cnt[k][p] = 0; last_hs_cyc[k][p] = 0; rsp_cnt[k][p] = 0;
        last_rsp_cyc[k][p] = 0; last_rsp_err[k][p] = 1'b0; last_rsp_rdata[k][p] = 32'd0;
      end
      wr_pulses[k] = 0; strobes[k] = 0; last_wr_addr[k] = 32'd0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step(); step(); step();
    chk1("reset_busy", 0, busy[0], 1'b0);
    chk("reset_rdata0", 0, rsp_rdata[0][0], 32'd0);
    rst_n = 1'b1;
    step();

    // Write then read back through port 0 with one wait state.
    issue(0, 0, 1'b1, 32'h10, 32'hDEADBEEF);
    issue(0, 0, 1'b0, 32'h10, 32'd0);
    chk("t1_write_pulses", 0, 32'(wr_pulses[0]), 32'd1);
    chk("t1_write_addr", 0, last_wr_addr[0], 32'h10);
    chk("t1_read_latency", 0, 32'(last_rsp_cyc[0][0] - last_hs_cyc[0][0]), 32'd3);
    chk("t1_read_data", 0, last_rsp_rdata[0][0], 32'hDEADBEEF);
    chk1("t1_read_err", 0, last_rsp_err[0][0], 1'b0);

    // Simultaneous held requests alternate starting with port 0.
    do_reset();
    req_we[0][0] = 1'b0; req_addr[0][0] = 32'h20;
    req_we[0][1] = 1'b0; req_addr[0][1] = 32'h24;
    hold(0, 1'b1, 1'b1, 4);
    chk("t2_grant0", 0, 32'(g_log[0]), 32'd0);
    chk("t2_grant1", 0, 32'(g_log[1]), 32'd1);
    chk("t2_grant2", 0, 32'(g_log[2]), 32'd0);
    chk("t2_grant3", 0, 32'(g_log[3]), 32'd1);

    // Misaligned and out-of-range requests on port 1.
    issue(0, 1, 1'b0, 32'h6, 32'd0);
    chk1("t3a_err", 0, last_rsp_err[0][1], 1'b1);
    chk("t3a_rdata", 0, last_rsp_rdata[0][1], 32'd0);
    chk("t3a_latency", 0, 32'(last_rsp_cyc[0][1] - last_hs_cyc[0][1]), 32'd1);
    issue(0, 1, 1'b0, 32'h400, 32'd0);
    chk1("t3b_err", 0, last_rsp_err[0][1], 1'b1);
    chk("t3b_rdata", 0, last_rsp_rdata[0][1], 32'd0);
    chk("t3b_latency", 0, 32'(last_rsp_cyc[0][1] - last_hs_cyc[0][1]), 32'd1);
    chk("t3_strobe_total", 0, 32'(strobes[0]), 32'd6);

    // No wait states: back-to-back port 0 reads.
    issue(1, 0, 1'b1, 32'h10, 32'hA5A55A5A);
    req_we[1][0] = 1'b0; req_addr[1][0] = 32'h10;
    hold(1, 1'b1, 1'b0, 2);
    chk("t4_ready_spacing", 1, 32'(g_cyc[1] - g_cyc[0]), 32'd3);
    chk("t4_read_latency", 1, 32'(last_rsp_cyc[1][0] - last_hs_cyc[1][0]), 32'd2);
    chk("t4_read_data", 1, last_rsp_rdata[1][0], 32'hA5A55A5A);

    // Reset while a write is waiting: the write must never reach memory.
    begin
      int h0;
      h0 = hs_cnt[0][0];
      req_we[0][0] = 1'b1; req_addr[0][0] = 32'h30; req_wdata[0][0] = 32'h55;
      req_valid[0][0] = 1'b1;
      for (int i = 0; i < 40; i++) begin
        step();
        if (hs_cnt[0][0] != h0) break;
      end
      req_valid[0][0] = 1'b0;
      chk1("t5_handshake", 0, hs_cnt[0][0] != h0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("t5_async_busy", 0, busy[0], 1'b0);
      chk("t5_async_addr", 0, mem_addr[0], 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("t5_mem_untouched", 0, env_mem[0][12], 32'd0);
      chk("t5_write_pulses", 0, 32'(wr_pulses[0]), 32'd1);
      req_we[0][0] = 1'b0; req_addr[0][0] = 32'h30;
      req_we[0][1] = 1'b0; req_addr[0][1] = 32'h34;
      hold(0, 1'b1, 1'b1, 2);
      chk("t5_grant0", 0, 32'(g_log[0]), 32'd0);
      chk("t5_grant1", 0, 32'(g_log[1]), 32'd1);
    end

    // Port 1 write between two port 0 reads of the same word.
    issue(0, 0, 1'b1, 32'h40, 32'h0BADF00D);
    issue(0, 0, 1'b0, 32'h40, 32'd0);
    chk("t6_first_read", 0, last_rsp_rdata[0][0], 32'h0BADF00D);
    issue(0, 1, 1'b1, 32'h40, 32'h12345678);
    chk1("t6_write_err", 0, last_rsp_err[0][1], 1'b0);
    chk("t6_rdata0_held", 0, rsp_rdata[0][0], 32'h0BADF00D);
    issue(0, 0, 1'b0, 32'h40, 32'd0);
    chk("t6_second_read", 0, last_rsp_rdata[0][0], 32'h12345678);

    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
